// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared types and widths for the VRAM arbiter
package vram_arb_pkg;

   localparam int VRAM_ADDR_W = 16;
   localparam int VRAM_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      RDWAIT = 2'd2,
      DONE   = 2'd3
   } host_state_t;

endpackage

// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - VRAM port arbiter: fixed-priority video reads, handshaked host access
module vram_arb
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_sel,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_valid,
   output logic [DATA_W-1:0] vid_data,
   input  logic              host_req,
   input  logic              host_wr,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data_in,
   output logic              host_busy,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_data_out,
   output logic              vram_sel,
   output logic              vram_wr,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [DATA_W-1:0] vram_data_in,
   input  logic [DATA_W-1:0] vram_data_out
);

   host_state_t       state_q, state_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] hdo_q, hdo_d;
   logic              vid_valid_q, vid_valid_d;

   // Host FSM next state, request latching and the VRAM port mux (video wins, reset silences the port)
   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      data_d       = data_q;
      hdo_d        = hdo_q;
      vram_sel     = 1'b0;
      vram_wr      = 1'b0;
      vram_addr    = addr_q;
      vram_data_in = data_q;
      case (state_q)
         IDLE: begin
            if (host_req) begin
               wr_d    = host_wr;
               addr_d  = host_addr;
               data_d  = host_data_in;
               state_d = PEND;
            end
         end
         PEND: begin
            if (!vid_sel) begin
               vram_sel = 1'b1;
               vram_wr  = wr_q;
               state_d  = wr_q ? DONE : RDWAIT;
            end
         end
         RDWAIT: begin
            hdo_d   = vram_data_out;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (vid_sel) begin
         vram_sel     = 1'b1;
         vram_wr      = 1'b0;
         vram_addr    = vid_addr;
         vram_data_in = '0;
      end
      if (reset) begin
         vram_sel = 1'b0;
         vram_wr  = 1'b0;
      end
   end

   assign vid_valid_d = vid_sel & ~reset;

   // State and latched-request registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         hdo_q       <= '0;
         vid_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         hdo_q       <= hdo_d;
         vid_valid_q <= vid_valid_d;
      end
   end

   assign host_busy     = (state_q != IDLE);
   assign host_ack      = (state_q == DONE) & ~reset;
   assign host_data_out = hdo_q;
   assign vid_valid     = vid_valid_q;
   assign vid_data      = vram_data_out;

endmodule

// File: tb/tb_vram_arb.sv
// tb/tb_vram_arb.sv - randomized check of vram_arb against a timestamp/shadow-memory model
module tb_vram_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        vid_sel;
   logic [15:0] vid_addr;
   logic        vid_valid;
   logic [15:0] vid_data;
   logic        host_req;
   logic        host_wr;
   logic [15:0] host_addr;
   logic [15:0] host_data_in;
   logic        host_busy;
   logic        host_ack;
   logic [15:0] host_data_out;
   logic        vram_sel;
   logic        vram_wr;
   logic [15:0] vram_addr;
   logic [15:0] vram_data_in;
   logic [15:0] vram_data_out = 16'h0000;

   logic [15:0] vram_mem [0:65535];
   logic [15:0] shadow   [0:65535];

   int n_vec = 0;
   int n_err = 0;
   int t     = 0;

   // model: one outstanding host request described by timestamps
   bit          m_active = 1'b0;
   bit          m_issued = 1'b0;
   int          m_t_acc  = 0;
   int          m_t_done = 0;
   bit          m_wr     = 1'b0;
   logic [15:0] m_addr   = 16'h0000;
   logic [15:0] m_data   = 16'h0000;
   logic [15:0] m_rd_word = 16'h0000;
   logic [15:0] m_hdo    = 16'h0000;
   bit          m_vv     = 1'b0;
   logic [15:0] m_vword  = 16'h0000;

   vram_arb dut (
      .clk           (clk),
      .reset         (reset),
      .vid_sel       (vid_sel),
      .vid_addr      (vid_addr),
      .vid_valid     (vid_valid),
      .vid_data      (vid_data),
      .host_req      (host_req),
      .host_wr       (host_wr),
      .host_addr     (host_addr),
      .host_data_in  (host_data_in),
      .host_busy     (host_busy),
      .host_ack      (host_ack),
      .host_data_out (host_data_out),
      .vram_sel      (vram_sel),
      .vram_wr       (vram_wr),
      .vram_addr     (vram_addr),
      .vram_data_in  (vram_data_in),
      .vram_data_out (vram_data_out)
   );

   always #5 clk = ~clk;

   // single-port VRAM with one-cycle read latency
   always @(posedge clk) begin
      if (vram_sel) begin
         if (vram_wr) vram_mem[vram_addr] <= vram_data_in;
         else         vram_data_out <= vram_mem[vram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, t, got, exp);
      end
   endtask

   // one clock cycle: drive inputs, check outputs against the model, advance the model
   task automatic step(input logic rst, input logic vs, input logic [15:0] va,
                       input logic rq, input logic rw, input logic [15:0] ra, input logic [15:0] rd);
      bit done_now, ack_exp, issue_now, was_active;
      @(negedge clk);
      reset        = rst;
      vid_sel      = vs;
      vid_addr     = va;
      host_req     = rq;
      host_wr      = rw;
      host_addr    = ra;
      host_data_in = rd;
      #1;
      was_active = m_active;
      done_now   = m_active && m_issued && (t == m_t_done);
      ack_exp    = done_now && !rst;
      issue_now  = m_active && !m_issued && (t > m_t_acc) && !vs && !rst;
      if (done_now && !m_wr) m_hdo = m_rd_word;

      chk("host_busy", 32'(host_busy), 32'(m_active));
      chk("host_ack", 32'(host_ack), 32'(ack_exp));
      chk("host_data_out", 32'(host_data_out), 32'(m_hdo));
      chk("vid_valid", 32'(vid_valid), 32'(m_vv));
      if (m_vv) chk("vid_data", 32'(vid_data), 32'(m_vword));
      if (rst) begin
         chk("vram_sel_rst", 32'(vram_sel), 32'd0);
         chk("vram_wr_rst", 32'(vram_wr), 32'd0);
      end else if (vs) begin
         chk("vram_sel_vid", 32'(vram_sel), 32'd1);
         chk("vram_wr_vid", 32'(vram_wr), 32'd0);
         chk("vram_addr_vid", 32'(vram_addr), 32'(va));
         chk("vram_din_vid", 32'(vram_data_in), 32'd0);
      end else begin
         chk("vram_sel", 32'(vram_sel), 32'(issue_now));
         chk("vram_wr", 32'(vram_wr), 32'(issue_now && m_wr));
         chk("vram_addr", 32'(vram_addr), 32'(m_addr));
         chk("vram_din", 32'(vram_data_in), 32'(m_data));
      end

      m_vv = vs && !rst;
      if (vs) m_vword = shadow[va];
      if (issue_now) begin
         m_issued = 1'b1;
         m_t_done = t + (m_wr ? 1 : 2);
         if (m_wr) shadow[m_addr] = m_data;
         else      m_rd_word = shadow[m_addr];
      end
      if (ack_exp) m_active = 1'b0;
      if (!was_active && rq && !rst) begin
         m_active = 1'b1;
         m_issued = 1'b0;
         m_t_acc  = t;
         m_wr     = rw;
         m_addr   = ra;
         m_data   = rd;
      end
      if (rst) begin
         m_active = 1'b0;
         m_issued = 1'b0;
         m_wr     = 1'b0;
         m_addr   = 16'h0000;
         m_data   = 16'h0000;
         m_hdo    = 16'h0000;
      end
      t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         vram_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
         shadow[i]   = 16'(i * 40503) ^ 16'h5A5A;
      end
      vram_mem[16'hF000] = 16'h3C42;
      shadow[16'hF000]   = 16'h3C42;
      reset = 1'b1; vid_sel = 1'b0; vid_addr = '0; host_req = 1'b0;
      host_wr = 1'b0; host_addr = '0; host_data_in = '0;
      @(posedge clk);

      // reset with video asking for the port
      step(1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0000, 16'h0000);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle(2);

      // host write then read-back
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'hBEEF);
      idle(3);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000);
      idle(4);

      // read deferred by five video cycles
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'hF000 + 16'(i), 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle(4);

      // video read during RDWAIT
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000);
      idle(1);
      step(1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle(3);

      // extra requests while busy and in DONE are ignored
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1235, 16'h1111);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1236, 16'h2222);
      idle(3);

      // reset in PEND, then in RDWAIT, then a clean request
      step(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h1235, 16'h0000);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle(2);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1235, 16'h0000);
      idle(1);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle(1);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1235, 16'h0000);
      idle(4);

      // random traffic over a small address window to force read-after-write hits
      for (int i = 0; i < 4000; i++) begin
         logic rst, vs, rq, rw;
         logic [15:0] va, ra, rd;
         rst = ($urandom_range(0, 199) == 0);
         vs  = ($urandom_range(0, 9) < 4);
         va  = ($urandom_range(0, 7) == 0) ? 16'hF000 : {12'h123, 4'($urandom)};
         rq  = ($urandom_range(0, 1) == 1);
         rw  = ($urandom_range(0, 1) == 1);
         ra  = {12'h123, 4'($urandom)};
         rd  = 16'($urandom);
         step(rst, vs, va, rq, rw, ra, rd);
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
